// File: rtl/bp_pkg.sv
// Shared defaults and small helpers for the bimodal branch predictor with BTB.
package bp_pkg;
   localparam int DEF_PC_W   = 32;
   localparam int DEF_IDX_W  = 4;
   localparam int DEF_ALIGN  = 2;
   localparam int DEF_CTR_W  = 2;
   localparam int DEF_STAT_W = 16;

   // Counter values in the upper half of the range predict taken.
   function automatic logic ctr_is_taken(input logic [3:0] ctr, input int ctr_w);
      return ctr >= 4'(1 << (ctr_w - 1));
   endfunction

   // Distance from a branch to its fall-through successor.
   function automatic int fall_through_step(input int align);
      return 1 << align;
   endfunction
endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state logic of a saturating up/down direction counter.
module bp_sat_ctr #(
   parameter int CTR_W = 2
) (
   input  logic [CTR_W-1:0] ctr_i,
   input  logic             up_i,
   output logic [CTR_W-1:0] ctr_o
);
   always_comb begin
      ctr_o = ctr_i;
      if (up_i) begin
         if (ctr_i != '1) ctr_o = ctr_i + CTR_W'(1);
      end else begin
         if (ctr_i != '0) ctr_o = ctr_i - CTR_W'(1);
      end
   end
endmodule

// File: rtl/bimodal_btb_predictor.sv
// Direct-mapped BTB with per-entry bimodal direction counters, one-cycle
// registered lookup, one resolved-branch update per cycle, and accuracy stats.
module bimodal_btb_predictor
   import bp_pkg::*;
#(
   parameter int PC_W   = DEF_PC_W,
   parameter int IDX_W  = DEF_IDX_W,
   parameter int ALIGN  = DEF_ALIGN,
   parameter int CTR_W  = DEF_CTR_W,
   parameter int STAT_W = DEF_STAT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pred_req,
   input  logic [PC_W-1:0]   pred_pc,
   output logic              pred_valid,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [PC_W-1:0]   pred_next_pc,
   input  logic              upd_valid,
   input  logic [PC_W-1:0]   upd_pc,
   input  logic              upd_taken,
   input  logic [PC_W-1:0]   upd_target,
   input  logic              stat_clear,
   output logic [STAT_W-1:0] stat_updates,
   output logic [STAT_W-1:0] stat_correct
);
   localparam int TAG_W   = PC_W - ALIGN - IDX_W;
   localparam int ENTRIES = 1 << IDX_W;
   localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);
   localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1 << (CTR_W - 1));
   localparam logic [PC_W-1:0]  FT_STEP     = PC_W'(fall_through_step(ALIGN));

   logic             valid_q  [ENTRIES];
   logic             valid_d  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [TAG_W-1:0] tag_d    [ENTRIES];
   logic [PC_W-1:0]  target_q [ENTRIES];
   logic [PC_W-1:0]  target_d [ENTRIES];
   logic [CTR_W-1:0] ctr_q    [ENTRIES];
   logic [CTR_W-1:0] ctr_d    [ENTRIES];

   logic              pred_valid_q, pred_valid_d;
   logic              pred_hit_q, pred_hit_d;
   logic              pred_taken_q, pred_taken_d;
   logic [PC_W-1:0]   pred_next_pc_q, pred_next_pc_d;
   logic [STAT_W-1:0] stat_updates_q, stat_updates_d;
   logic [STAT_W-1:0] stat_correct_q, stat_correct_d;

   logic [IDX_W-1:0] p_idx, u_idx;
   logic [TAG_W-1:0] p_tag, u_tag;
   logic             p_hit, p_taken;
   logic             u_hit, u_pred_taken, u_correct;
   logic [PC_W-1:0]  u_pred_next, u_act_next;
   logic [CTR_W-1:0] u_ctr_next;

   assign p_idx = pred_pc[ALIGN +: IDX_W];
   assign p_tag = pred_pc[PC_W-1 -: TAG_W];
   assign u_idx = upd_pc[ALIGN +: IDX_W];
   assign u_tag = upd_pc[PC_W-1 -: TAG_W];

   // Both lookups read the table as it stood before this cycle's write.
   always_comb begin
      p_hit          = valid_q[p_idx] && (tag_q[p_idx] == p_tag);
      p_taken        = p_hit && ctr_is_taken(4'(ctr_q[p_idx]), CTR_W);
      pred_valid_d   = pred_req;
      pred_hit_d     = pred_req && p_hit;
      pred_taken_d   = pred_req && p_taken;
      pred_next_pc_d = '0;
      if (pred_req) pred_next_pc_d = p_taken ? target_q[p_idx] : pred_pc + FT_STEP;
   end

   always_comb begin
      u_hit        = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
      u_pred_taken = u_hit && ctr_is_taken(4'(ctr_q[u_idx]), CTR_W);
      u_pred_next  = u_pred_taken ? target_q[u_idx] : upd_pc + FT_STEP;
      u_act_next   = upd_taken ? upd_target : upd_pc + FT_STEP;
      u_correct    = (u_pred_next == u_act_next);
   end

   bp_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
      .ctr_i (ctr_q[u_idx]),
      .up_i  (upd_taken),
      .ctr_o (u_ctr_next)
   );

   // A not-taken miss carries no useful target, so it never allocates.
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (upd_valid) begin
         if (u_hit) begin
            ctr_d[u_idx] = u_ctr_next;
            if (upd_taken) target_d[u_idx] = upd_target;
         end else if (upd_taken) begin
            valid_d[u_idx]  = 1'b1;
            tag_d[u_idx]    = u_tag;
            target_d[u_idx] = upd_target;
            ctr_d[u_idx]    = CTR_WEAK_T;
         end
      end
   end

   always_comb begin
      stat_updates_d = stat_updates_q;
      stat_correct_d = stat_correct_q;
      if (stat_clear) begin
         stat_updates_d = '0;
         stat_correct_d = '0;
      end else if (upd_valid) begin
         if (stat_updates_q != '1) stat_updates_d = stat_updates_q + STAT_W'(1);
         if (u_correct && (stat_correct_q != '1)) stat_correct_d = stat_correct_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WEAK_NT;
         end
         pred_valid_q   <= 1'b0;
         pred_hit_q     <= 1'b0;
         pred_taken_q   <= 1'b0;
         pred_next_pc_q <= '0;
         stat_updates_q <= '0;
         stat_correct_q <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= valid_d[i];
            tag_q[i]    <= tag_d[i];
            target_q[i] <= target_d[i];
            ctr_q[i]    <= ctr_d[i];
         end
         pred_valid_q   <= pred_valid_d;
         pred_hit_q     <= pred_hit_d;
         pred_taken_q   <= pred_taken_d;
         pred_next_pc_q <= pred_next_pc_d;
         stat_updates_q <= stat_updates_d;
         stat_correct_q <= stat_correct_d;
      end
   end

   assign pred_valid   = pred_valid_q;
   assign pred_hit     = pred_hit_q;
   assign pred_taken   = pred_taken_q;
   assign pred_next_pc = pred_next_pc_q;
   assign stat_updates = stat_updates_q;
   assign stat_correct = stat_correct_q;
endmodule

// File: tb/tb_bimodal_btb_predictor.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural table model of the predictor (default parameters).
module tb_bimodal_btb_predictor;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        pred_req;
   logic [31:0] pred_pc;
   logic        pred_valid, pred_hit, pred_taken;
   logic [31:0] pred_next_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        stat_clear;
   logic [15:0] stat_updates, stat_correct;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit        v;
      bit [31:0] tag;
      bit [31:0] tgt;
      int        ctr;
   } ent_t;

   ent_t model [16];
   int   m_upd, m_cor;
   bit        exp_pv, exp_hit, exp_taken;
   bit [31:0] exp_npc;

   bimodal_btb_predictor dut (
      .clk(clk), .rst_n(rst_n),
      .pred_req(pred_req), .pred_pc(pred_pc),
      .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken),
      .pred_next_pc(pred_next_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .stat_clear(stat_clear), .stat_updates(stat_updates), .stat_correct(stat_correct)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) begin
         model[i].v = 0; model[i].tag = 0; model[i].tgt = 0; model[i].ctr = 1;
      end
      m_upd = 0;
      m_cor = 0;
   endfunction

   function automatic void model_predict(input bit [31:0] pc, output bit hit,
                                         output bit taken, output bit [31:0] npc);
      int idx;
      idx   = int'((pc / 4) % 16);
      hit   = model[idx].v && (model[idx].tag == pc / 64);
      taken = hit && (model[idx].ctr >= 2);
      npc   = taken ? model[idx].tgt : pc + 32'd4;
   endfunction

   function automatic void model_update(input bit [31:0] pc, input bit tk, input bit [31:0] tgt);
      bit hit, ptk;
      bit [31:0] pnpc, anpc;
      int idx;
      idx = int'((pc / 4) % 16);
      model_predict(pc, hit, ptk, pnpc);
      anpc = tk ? tgt : pc + 32'd4;
      if (m_upd < 65535) m_upd++;
      if (pnpc == anpc && m_cor < 65535) m_cor++;
      if (hit) begin
         if (tk) model[idx].ctr = (model[idx].ctr < 3) ? model[idx].ctr + 1 : 3;
         else    model[idx].ctr = (model[idx].ctr > 0) ? model[idx].ctr - 1 : 0;
         if (tk) model[idx].tgt = tgt;
      end else if (tk) begin
         model[idx].v = 1; model[idx].tag = pc / 64; model[idx].tgt = tgt; model[idx].ctr = 2;
      end
   endfunction

   task automatic drive_cycle(input bit req, input bit [31:0] ppc, input bit upd,
                              input bit [31:0] upc, input bit tk, input bit [31:0] tgt,
                              input bit clr);
      pred_req = req; pred_pc = ppc;
      upd_valid = upd; upd_pc = upc; upd_taken = tk; upd_target = tgt;
      stat_clear = clr;
      exp_pv = req; exp_hit = 0; exp_taken = 0; exp_npc = 0;
      if (req) model_predict(ppc, exp_hit, exp_taken, exp_npc);
      if (upd) model_update(upc, tk, tgt);
      if (clr) begin m_upd = 0; m_cor = 0; end
      @(posedge clk); #1;
      $display("txn req=%0d pc=%h upd=%0d upc=%h tk=%0d tgt=%h clr=%0d -> v=%0d hit=%0d tk=%0d npc=%h st=%0d/%0d",
               req, ppc, upd, upc, tk, tgt, clr, pred_valid, pred_hit, pred_taken,
               pred_next_pc, stat_updates, stat_correct);
      pred_req = 0; upd_valid = 0; stat_clear = 0;
   endtask

   task automatic do_pred(input bit [31:0] pc);
      drive_cycle(1, pc, 0, 0, 0, 0, 0);
   endtask

   task automatic do_upd(input bit [31:0] pc, input bit tk, input bit [31:0] tgt);
      drive_cycle(0, 0, 1, pc, tk, tgt, 0);
   endtask

   task automatic test_reset();
      rst_n = 0; pred_req = 1; pred_pc = 32'h100; upd_valid = 0; upd_pc = 0;
      upd_taken = 0; upd_target = 0; stat_clear = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pred_valid); end
      checks++; if (pred_hit !== 1'b0 || pred_taken !== 1'b0) begin errors++; $display("FAIL reset_hit_taken: got %b%b want 00", pred_hit, pred_taken); end
      checks++; if (pred_next_pc !== 32'h0) begin errors++; $display("FAIL reset_npc: got %h want 0", pred_next_pc); end
      checks++; if (stat_updates !== 16'd0 || stat_correct !== 16'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_updates, stat_correct); end
      pred_req = 0;
      rst_n = 1;
      model_reset();
      drive_cycle(0, 0, 0, 0, 0, 0, 0);
      checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", pred_valid); end
   endtask

   task automatic test_directed();
      do_pred(32'h100);
      checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", pred_valid); end
      checks++; if (pred_hit !== 1'b0 || pred_taken !== 1'b0) begin errors++; $display("FAIL first_miss: got %b%b want 00", pred_hit, pred_taken); end
      checks++; if (pred_next_pc !== 32'h104) begin errors++; $display("FAIL first_npc: got %h want 00000104", pred_next_pc); end
      do_upd(32'h100, 1, 32'h200);
      checks++; if (stat_updates !== 16'd1 || stat_correct !== 16'd0) begin errors++; $display("FAIL alloc_stats: got %0d/%0d want 1/0", stat_updates, stat_correct); end
      do_pred(32'h100);
      checks++; if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_next_pc !== 32'h200) begin errors++; $display("FAIL alloc_pred: got %b%b %h want 11 00000200", pred_hit, pred_taken, pred_next_pc); end
      repeat (5) do_upd(32'h100, 1, 32'h200);
      checks++; if (stat_updates !== 16'd6 || stat_correct !== 16'd5) begin errors++; $display("FAIL train_stats: got %0d/%0d want 6/5", stat_updates, stat_correct); end
      do_upd(32'h100, 0, 32'h0);
      do_pred(32'h100);
      checks++; if (pred_taken !== 1'b1 || pred_next_pc !== 32'h200) begin errors++; $display("FAIL one_nt: got %b %h want 1 00000200", pred_taken, pred_next_pc); end
      do_upd(32'h100, 0, 32'h0);
      do_pred(32'h100);
      checks++; if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_next_pc !== 32'h104) begin errors++; $display("FAIL two_nt: got %b%b %h want 10 00000104", pred_hit, pred_taken, pred_next_pc); end
      do_upd(32'h140, 1, 32'h300);
      do_pred(32'h140);
      checks++; if (pred_hit !== 1'b1 || pred_next_pc !== 32'h300) begin errors++; $display("FAIL alias_new: got %b %h want 1 00000300", pred_hit, pred_next_pc); end
      do_pred(32'h100);
      checks++; if (pred_hit !== 1'b0 || pred_next_pc !== 32'h104) begin errors++; $display("FAIL alias_old: got %b %h want 0 00000104", pred_hit, pred_next_pc); end
      drive_cycle(1, 32'h180, 1, 32'h180, 1, 32'h400, 0);
      checks++; if (pred_hit !== 1'b0 || pred_next_pc !== 32'h184) begin errors++; $display("FAIL no_bypass: got %b %h want 0 00000184", pred_hit, pred_next_pc); end
      do_pred(32'h180);
      checks++; if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_next_pc !== 32'h400) begin errors++; $display("FAIL after_write: got %b%b %h want 11 00000400", pred_hit, pred_taken, pred_next_pc); end
      checks++; if (stat_updates !== 16'd10 || stat_correct !== 16'd5) begin errors++; $display("FAIL directed_stats: got %0d/%0d want 10/5", stat_updates, stat_correct); end
      do_pred(32'hFFFF_FFFC);
      checks++; if (pred_hit !== 1'b0 || pred_next_pc !== 32'h0) begin errors++; $display("FAIL wrap_npc: got %b %h want 0 00000000", pred_hit, pred_next_pc); end
      drive_cycle(0, 0, 1, 32'h100, 1, 32'h200, 1);
      checks++; if (stat_updates !== 16'd0 || stat_correct !== 16'd0) begin errors++; $display("FAIL clear_priority: got %0d/%0d want 0/0", stat_updates, stat_correct); end
   endtask

   function automatic bit [31:0] rand_pc();
      if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
      return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
   endfunction

   task automatic test_random();
      bit req, upd, tk, clr;
      bit [31:0] ppc, upc, tgt;
      for (int n = 0; n < 400; n++) begin
         req = 1'($urandom_range(0, 1));
         upd = ($urandom_range(0, 3) != 0);
         tk  = ($urandom_range(0, 9) < 7);
         clr = ($urandom_range(0, 39) == 0);
         ppc = rand_pc();
         upc = ($urandom_range(0, 1) == 1) ? ppc : rand_pc();
         tgt = $urandom() & 32'hFFFF_FFFC;
         drive_cycle(req, ppc, upd, upc, tk, tgt, clr);
         checks++; if (pred_valid !== exp_pv) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, pred_valid, exp_pv); end
         if (req) begin
            checks++;
            if (pred_hit !== exp_hit || pred_taken !== exp_taken || pred_next_pc !== exp_npc) begin
               errors++;
               $display("FAIL rnd_pred[%0d] pc=%h: got %b%b %h want %b%b %h", n, ppc,
                        pred_hit, pred_taken, pred_next_pc, exp_hit, exp_taken, exp_npc);
            end
         end
         checks++;
         if (stat_updates !== 16'(m_upd) || stat_correct !== 16'(m_cor)) begin
            errors++;
            $display("FAIL rnd_stats[%0d]: got %0d/%0d want %0d/%0d", n, stat_updates, stat_correct, m_upd, m_cor);
         end
      end
   endtask

   task automatic test_async_reset();
      do_upd(32'h100, 1, 32'h200);
      do_upd(32'h180, 1, 32'h400);
      do_pred(32'h100);
      checks++; if (pred_valid !== 1'b1 || stat_updates == 16'd0) begin errors++; $display("FAIL pre_reset: got v=%b upd=%0d want v=1 upd>0", pred_valid, stat_updates); end
      #2;
      rst_n = 0;
      #1;
      checks++; if (pred_valid !== 1'b0 || pred_next_pc !== 32'h0) begin errors++; $display("FAIL async_pred: got %b %h want 0 00000000", pred_valid, pred_next_pc); end
      checks++; if (stat_updates !== 16'd0 || stat_correct !== 16'd0) begin errors++; $display("FAIL async_stats: got %0d/%0d want 0/0", stat_updates, stat_correct); end
      @(posedge clk); #1;
      rst_n = 1;
      model_reset();
      do_pred(32'h100);
      checks++; if (pred_valid !== 1'b1 || pred_hit !== 1'b0 || pred_next_pc !== 32'h104) begin errors++; $display("FAIL post_reset_100: got %b%b %h want 10 00000104", pred_valid, pred_hit, pred_next_pc); end
      do_pred(32'h180);
      checks++; if (pred_hit !== 1'b0 || pred_next_pc !== 32'h184) begin errors++; $display("FAIL post_reset_180: got %b %h want 0 00000184", pred_hit, pred_next_pc); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
